mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter on the CPU data bus, in parallel with dmem.
- Shares the bus signals with dmem: write enable, data address, write data, read data.
- Stores stores-to-TXDATA in an 8-entry byte FIFO, then serialises each byte 8N1 on a single tx pin.
- CPU polls STATUS through the read-data path; top muxes rdata over dmem's ReadData when hit=1.

---
 rtl/mmio_uart_tx_pkg.sv | 22 ++
 rtl/uart_tx_fifo.sv | 53 +++++
 rtl/mmio_uart_tx.sv | 150 +++++++++++++++
 tb/tb_mmio_uart_tx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// register offsets, STATUS bit layout and serialiser state encoding.
package mmio_uart_tx_pkg;

    localparam logic [1:0] OffTxData = 2'd0;
    localparam logic [1:0] OffStatus = 2'd1;

    localparam int unsigned StatBusy     = 0;
    localparam int unsigned StatFull     = 1;
    localparam int unsigned StatEmpty    = 2;
    localparam int unsigned StatOverflow = 3;
    localparam int unsigned StatCountLsb = 4;
    localparam int unsigned StatCountMsb = 7;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } txState_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART serialiser; a push into a full FIFO is
// still accepted when a pop happens on the same edge.
module uart_tx_fifo #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [Width-1:0]         pushData,
    input  logic                     pop,
    output logic [Width-1:0]         popData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   count
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  rdPtr;
    logic [PtrW-1:0]  wrPtr;
    logic             doPush;
    logic             doPop;

    assign empty   = (count == '0);
    assign full    = (count == (PtrW + 1)'(Depth));
    assign doPop   = pop && !empty;
    assign doPush  = push && (!full || doPop);
    assign popData = mem[rdPtr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            if (doPush && !doPop) begin
                count <= count + 1'b1;
            end else if (doPop && !doPush) begin
                count <= count - 1'b1;
            end
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus decode, STATUS read mux,
// overflow tracking and the serialiser FSM around a byte FIFO.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        tx
);

    localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
    localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BaudW-1:0] BaudMax = BaudW'(CLKS_PER_BIT - 1);

    txState_e         state;
    logic [7:0]       shiftReg;
    logic [BaudW-1:0] baudCnt;
    logic [2:0]       bitIdx;
    logic             overflow;

    logic [1:0]       offset;
    logic             wrTx;
    logic             wrStatus;
    logic             fifoPop;
    logic [7:0]       fifoHead;
    logic             fifoFull;
    logic             fifoEmpty;
    logic [CntW-1:0]  fifoCount;
    logic [3:0]       countSat;
    logic [31:0]      status;
    logic             baudEnd;
    logic             unusedBits;

    assign unusedBits = ^{DataAdr[1:0], WriteData[31:8]};

    assign hit      = (DataAdr[31:4] == BASE_ADDR[31:4]);
    assign offset   = DataAdr[3:2];
    assign wrTx     = MemWrite && hit && (offset == OffTxData);
    assign wrStatus = MemWrite && hit && (offset == OffStatus);
    assign fifoPop  = (state == StIdle) && !fifoEmpty;
    assign baudEnd  = (baudCnt == BaudMax);

    uart_tx_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (8)
    ) uFifo (
        .clk      (clk),
        .reset    (reset),
        .push     (wrTx),
        .pushData (WriteData[7:0]),
        .pop      (fifoPop),
        .popData  (fifoHead),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .count    (fifoCount)
    );

    // A dropped push and a clear on the same edge leave overflow set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (wrTx && fifoFull && !fifoPop) begin
            overflow <= 1'b1;
        end else if (wrStatus && WriteData[StatOverflow]) begin
            overflow <= 1'b0;
        end
    end

    always_comb begin
        countSat = (32'(fifoCount) > 32'd15) ? 4'hF : 4'(fifoCount);
        status                             = '0;
        status[StatBusy]                   = (state != StIdle);
        status[StatFull]                   = fifoFull;
        status[StatEmpty]                  = fifoEmpty;
        status[StatOverflow]               = overflow;
        status[StatCountMsb:StatCountLsb]  = countSat;
        rdata = (hit && (offset == OffStatus)) ? status : 32'd0;
    end

    // tx is registered and updated together with the state it belongs to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= StIdle;
            tx       <= 1'b1;
            shiftReg <= '0;
            baudCnt  <= '0;
            bitIdx   <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    tx <= 1'b1;
                    if (!fifoEmpty) begin
                        shiftReg <= fifoHead;
                        baudCnt  <= '0;
                        tx       <= 1'b0;
                        state    <= StStart;
                    end
                end
                StStart: begin
                    if (baudEnd) begin
                        baudCnt <= '0;
                        bitIdx  <= '0;
                        tx      <= shiftReg[0];
                        state   <= StData;
                    end else begin
                        baudCnt <= baudCnt + 1'b1;
                    end
                end
                StData: begin
                    if (baudEnd) begin
                        baudCnt <= '0;
                        if (bitIdx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= StStop;
                        end else begin
                            shiftReg <= shiftReg >> 1;
                            tx       <= shiftReg[1];
                            bitIdx   <= bitIdx + 1'b1;
                        end
                    end else begin
                        baudCnt <= baudCnt + 1'b1;
                    end
                end
                StStop: begin
                    if (baudEnd) begin
                        baudCnt <= '0;
                        tx      <= 1'b1;
                        state   <= StIdle;
                    end else begin
                        baudCnt <= baudCnt + 1'b1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: frame-level queue model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_mmio_uart_tx;

    localparam logic [31:0] Base  = 32'hFFFF_0000;
    localparam int          Clks  = 4;
    localparam int          Depth = 8;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] rdata;
    logic        hit;
    logic        tx;

    int errors = 0;
    int checks = 0;

    mmio_uart_tx #(
        .BASE_ADDR    (Base),
        .CLKS_PER_BIT (Clks),
        .FIFO_DEPTH   (Depth)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .rdata     (rdata),
        .hit       (hit),
        .tx        (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queue of pending bytes, position within the current 10-bit frame.
    byte unsigned mq[$];
    int           framePos = -1;
    logic [7:0]   cur = 8'h00;
    bit           mOvf = 1'b0;

    initial begin
        forever begin : modelStep
            bit hitNow;
            bit wrT;
            bit wrS;
            @(posedge clk or negedge reset);
            if (!reset) begin
                mq.delete();
                framePos = -1;
                mOvf = 1'b0;
            end else begin
                hitNow = (DataAdr[31:4] == Base[31:4]);
                wrT = MemWrite && hitNow && (DataAdr[3:2] == 2'd0);
                wrS = MemWrite && hitNow && (DataAdr[3:2] == 2'd1);
                if (framePos < 0) begin
                    if (mq.size() > 0) begin
                        cur = mq.pop_front();
                        framePos = 0;
                    end
                end else begin
                    framePos++;
                    if (framePos == 10 * Clks) framePos = -1;
                end
                if (wrS && WriteData[3]) mOvf = 1'b0;
                if (wrT) begin
                    if (mq.size() < Depth) mq.push_back(WriteData[7:0]);
                    else mOvf = 1'b1;
                end
            end
        end
    end

    function automatic logic expTx();
        logic [9:0] frame;
        if (framePos < 0) return 1'b1;
        frame = {1'b1, cur, 1'b0};
        return frame[framePos / Clks];
    endfunction

    function automatic logic [31:0] expRdata();
        int n;
        logic [31:0] st;
        if (DataAdr[31:4] != Base[31:4]) return 32'd0;
        if (DataAdr[3:2] != 2'd1) return 32'd0;
        n = mq.size();
        st = 32'd0;
        st[0] = (framePos >= 0);
        st[1] = (n == Depth);
        st[2] = (n == 0);
        st[3] = mOvf;
        st[7:4] = (n > 15) ? 4'hF : 4'(n);
        return st;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            check("model_tx", {31'd0, tx}, {31'd0, expTx()});
            check("model_hit", {31'd0, hit}, {31'd0, (DataAdr[31:4] == Base[31:4])});
            check("model_rdata", rdata, expRdata());
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
        MemWrite = 1'b1;
        DataAdr = a;
        WriteData = d;
        @(posedge clk);
        #2;
        MemWrite = 1'b0;
        DataAdr = Base + 32'd4;
        WriteData = 32'd0;
    endtask

    task automatic checkStatus(input string name, input logic [31:0] exp);
        @(negedge clk);
        check(name, rdata, exp);
    endtask

    task automatic checkFrame(input string name, input logic [9:0] bits);
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < Clks; c++) begin
                @(negedge clk);
                check(name, {31'd0, tx}, {31'd0, bits[i]});
                check({name, "_busy"}, {31'd0, rdata[0]}, 32'd1);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        reset = 1'b0;
        MemWrite = 1'b0;
        DataAdr = Base + 32'd4;
        WriteData = 32'd0;
        idle(3);
        reset = 1'b1;
        checkStatus("reset_status", 32'h0000_0004);
        check("reset_tx", {31'd0, tx}, 32'd1);

        // Decode: outside window and reserved offset.
        idle(1);
        MemWrite = 1'b1;
        DataAdr = Base + 32'h10;
        WriteData = 32'h41;
        @(negedge clk);
        check("decode_miss_hit", {31'd0, hit}, 32'd0);
        check("decode_miss_rdata", rdata, 32'd0);
        @(posedge clk);
        #2;
        DataAdr = Base + 32'h8;
        @(negedge clk);
        check("decode_rsvd_hit", {31'd0, hit}, 32'd1);
        check("decode_rsvd_rdata", rdata, 32'd0);
        @(posedge clk);
        #2;
        MemWrite = 1'b0;
        DataAdr = Base + 32'd4;
        WriteData = 32'd0;
        idle(2);
        checkStatus("decode_status", 32'h0000_0004);
        check("decode_tx", {31'd0, tx}, 32'd1);

        // Single byte 0x55.
        idle(1);
        busWrite(Base, 32'h55);
        @(posedge clk);
        #2;
        checkFrame("single_frame", 10'b1010101010);
        checkStatus("single_done", 32'h0000_0004);

        // Back-to-back 0xA5, 0x3C with one idle cycle between frames.
        idle(1);
        busWrite(Base, 32'hA5);
        busWrite(Base, 32'h3C);
        checkFrame("b2b_frame_a5", 10'b1101001010);
        @(negedge clk);
        check("b2b_gap_tx", {31'd0, tx}, 32'd1);
        check("b2b_gap_busy", {31'd0, rdata[0]}, 32'd0);
        checkFrame("b2b_frame_3c", 10'b1001111000);
        checkStatus("b2b_done", 32'h0000_0004);

        // Overflow: ten consecutive pushes, then clear.
        idle(1);
        for (int i = 0; i < 10; i++) busWrite(Base, 32'(i + 1));
        checkStatus("ovf_status", 32'h0000_008B);
        idle(1);
        busWrite(Base + 32'd4, 32'h8);
        checkStatus("ovf_clear", 32'h0000_0083);

        // Push on the pop edge while full.
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rdata[0] == 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        check("fullpop_wait_idle", {31'd0, found}, 32'd1);
        #1;
        MemWrite = 1'b1;
        DataAdr = Base;
        WriteData = 32'hEE;
        @(posedge clk);
        #2;
        MemWrite = 1'b0;
        DataAdr = Base + 32'd4;
        WriteData = 32'd0;
        checkStatus("fullpop_status", 32'h0000_0083);

        // Reset mid-frame.
        idle(Clks * 5);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_tx", {31'd0, tx}, 32'd1);
        check("midrst_status", rdata, 32'h0000_0004);
        idle(2);
        reset = 1'b1;
        idle(Clks * 12);
        checkStatus("post_rst_status", 32'h0000_0004);
        check("post_rst_tx", {31'd0, tx}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
